// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
//   Characterises an unsigned WxW approximate multiplier. Accepts a stream of
//   (x, y, z_approx) triples, computes the exact product and accumulates
//   error statistics over a window of 2^LOG2N accepted samples.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                begins a new window (honoured in IDLE or DONE only)
//   in_valid / in_ready  input handshake; accept = in_valid & in_ready
//   x, y, z_approx       operands and approximate product under test
//   busy                 high while the window is running or draining
//   done                 one-cycle pulse when results become final
//   err_abs_sum          sum of |x*y - z_approx|
//   err_sgn_sum          two's-complement sum of (x*y - z_approx)
//   err_max              maximum |x*y - z_approx|
//   err_nz_cnt           number of samples with nonzero error
module approx_mult_err_monitor #(
  parameter int unsigned W     = 8,
  parameter int unsigned LOG2N = 16,
  parameter int unsigned ACC_W = 2*W + LOG2N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       x,
  input  logic [W-1:0]       y,
  input  logic [2*W-1:0]     z_approx,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   err_abs_sum,
  output logic [ACC_W:0]     err_sgn_sum,
  output logic [2*W-1:0]     err_max,
  output logic [LOG2N:0]     err_nz_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Count value at which the current accept is the last one of the window.
  localparam logic [LOG2N:0] LAST = {1'b0, {LOG2N{1'b1}}};

  state_t state_q, state_d;

  logic [LOG2N:0] cnt_q;
  logic           done_q;

  // Stage 0: captured triple (only written on accept)
  logic           v0_q;
  logic [W-1:0]   x_q, y_q;
  logic [2*W-1:0] z_q;

  // Stage 1: signed error and its magnitude
  logic           v1_q;
  logic [2*W:0]   e_q;
  logic [2*W-1:0] abs_q;

  // Results
  logic [ACC_W-1:0] abs_sum_q;
  logic [ACC_W:0]   sgn_sum_q;
  logic [2*W-1:0]   max_q;
  logic [LOG2N:0]   nz_q;

  logic           accept;
  logic           start_ok;
  logic [2*W-1:0] prod;
  logic [2*W:0]   e_d;
  logic [2*W:0]   e_neg;
  logic [2*W-1:0] abs_d;

  assign accept   = in_valid && (state_q == RUN);
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && (cnt_q == LAST)) state_d = DRAIN;
      DRAIN:   if (!v0_q && !v1_q) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Error is formed one bit wider than the product so the sign survives.
  always_comb begin
    prod  = {{W{1'b0}}, x_q} * {{W{1'b0}}, y_q};
    e_d   = {1'b0, prod} - {1'b0, z_q};
    e_neg = '0 - e_d;
    abs_d = e_d[2*W] ? e_neg[2*W-1:0] : e_d[2*W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // High only on the DRAIN->DONE transition, i.e. the first DONE cycle.
      done_q  <= (state_q == DRAIN) && (state_d == DONE);
      if (start_ok)    cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      v1_q  <= 1'b0;
      e_q   <= '0;
      abs_q <= '0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        x_q <= x;
        y_q <= y;
        z_q <= z_approx;
      end
      v1_q <= v0_q;
      if (v0_q) begin
        e_q   <= e_d;
        abs_q <= abs_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_sum_q <= '0;
      sgn_sum_q <= '0;
      max_q     <= '0;
      nz_q      <= '0;
    end else if (start_ok) begin
      abs_sum_q <= '0;
      sgn_sum_q <= '0;
      max_q     <= '0;
      nz_q      <= '0;
    end else if (v1_q) begin
      abs_sum_q <= abs_sum_q + ACC_W'(abs_q);
      sgn_sum_q <= sgn_sum_q + {{(ACC_W-2*W){e_q[2*W]}}, e_q};
      if (abs_q > max_q) max_q <= abs_q;
      nz_q      <= nz_q + {{LOG2N{1'b0}}, |abs_q};
    end
  end

  assign in_ready    = (state_q == RUN);
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = done_q;
  assign err_abs_sum = abs_sum_q;
  assign err_sgn_sum = sgn_sum_q;
  assign err_max     = max_q;
  assign err_nz_cnt  = nz_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
module tb_approx_mult_err_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Small-window instance (LOG2N = 2)
  logic        s, v, rdy, bsy, dn;
  logic [7:0]  xi, yi;
  logic [15:0] zi;
  logic [17:0] abs_sum;
  logic [18:0] sgn_sum;
  logic [15:0] emax;
  logic [2:0]  nz;

  // Full-window instance (LOG2N = 16)
  logic        s16, v16, rdy16, bsy16, dn16;
  logic [7:0]  x16, y16;
  logic [15:0] z16;
  logic [31:0] abs16;
  logic [32:0] sgn16;
  logic [15:0] max16;
  logic [16:0] nz16;

  int n_cmp = 0;
  int n_err = 0;

  approx_mult_err_monitor #(.W(8), .LOG2N(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(s), .in_valid(v), .in_ready(rdy),
    .x(xi), .y(yi), .z_approx(zi), .busy(bsy), .done(dn),
    .err_abs_sum(abs_sum), .err_sgn_sum(sgn_sum), .err_max(emax), .err_nz_cnt(nz)
  );

  approx_mult_err_monitor #(.W(8), .LOG2N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .in_valid(v16), .in_ready(rdy16),
    .x(x16), .y(y16), .z_approx(z16), .busy(bsy16), .done(dn16),
    .err_abs_sum(abs16), .err_sgn_sum(sgn16), .err_max(max16), .err_nz_cnt(nz16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    s = 1'b1;
    step();
    s = 1'b0;
  endtask

  // Present one triple and hold it until accepted (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
    bit acc;
    acc = 1'b0;
    xi = a; yi = b; zi = c; v = 1'b1;
    for (int k = 0; k < 10 && !acc; k++) begin
      acc = (rdy === 1'b1);
      step();
    end
    v = 1'b0;
    if (!acc) chk("send_accept_timeout", 64'(acc), 64'(1));
  endtask

  // Count cycles from the last accept edge until done is seen.
  task automatic wait_done(input int n0, input int exp_n, input string tag);
    int n;
    bit seen;
    n = n0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      step();
      n++;
      if (dn === 1'b1) seen = 1'b1;
    end
    chk(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic chk_results(input string tag, input logic [17:0] ea, input logic [18:0] es,
                             input logic [15:0] em, input logic [2:0] en);
    chk({tag, "_abs"}, 64'(abs_sum), 64'(ea));
    chk({tag, "_sgn"}, 64'($signed(sgn_sum)), 64'($signed(es)));
    chk({tag, "_max"}, 64'(emax), 64'(em));
    chk({tag, "_nz"},  64'(nz), 64'(en));
  endtask

  initial begin
    bit any_done;
    bit rdy_ok;
    int n;
    bit seen;

    rst_n = 1'b0;
    s = 1'b0; v = 1'b0; xi = '0; yi = '0; zi = '0;
    s16 = 1'b0; v16 = 1'b0; x16 = '0; y16 = '0; z16 = '0;
    step();
    step();

    chk("rst_in_ready", 64'(rdy), 64'(0));
    chk("rst_busy", 64'(bsy), 64'(0));
    chk("rst_done", 64'(dn), 64'(0));
    chk_results("rst", 18'd0, 19'd0, 16'd0, 3'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(rdy), 64'(0));

    // Window aborted by reset
    pulse_start();
    chk("run_in_ready", 64'(rdy), 64'(1));
    chk("run_busy", 64'(bsy), 64'(1));
    send(8'd255, 8'd255, 16'd0);
    send(8'd255, 8'd255, 16'd0);
    step();
    chk("live_abs", 64'(abs_sum), 64'(65025));
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(rdy), 64'(0));
    chk("abort_busy", 64'(bsy), 64'(0));
    chk_results("abort", 18'd0, 19'd0, 16'd0, 3'd0);
    any_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (dn !== 1'b0) any_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (dn !== 1'b0) any_done = 1'b1;
    end
    chk("abort_no_done", 64'(any_done), 64'(0));
    chk("abort_idle", 64'(rdy), 64'(0));

    // Continuous window: errors 0, +4, -2, +25
    pulse_start();
    send(8'd3,   8'd5,   16'd15);
    send(8'd10,  8'd10,  16'd96);
    send(8'd2,   8'd7,   16'd16);
    send(8'd255, 8'd255, 16'd65000);
    chk("drain_in_ready", 64'(rdy), 64'(0));
    chk("drain_busy", 64'(bsy), 64'(1));
    wait_done(0, 3, "cont_done_latency");
    chk_results("cont", 18'd31, 19'd27, 16'd25, 3'd3);
    chk("cont_done_busy", 64'(bsy), 64'(0));

    // Start in the done cycle: next window with bubbles, start pulsed in RUN and DRAIN
    pulse_start();
    chk("b2b_done_fell", 64'(dn), 64'(0));
    chk("b2b_busy", 64'(bsy), 64'(1));
    chk_results("b2b_clear", 18'd0, 19'd0, 16'd0, 3'd0);
    rdy_ok = 1'b1;
    send(8'd3, 8'd5, 16'd15);
    s = 1'b1;
    step();
    s = 1'b0;
    if (rdy !== 1'b1) rdy_ok = 1'b0;
    step();
    if (rdy !== 1'b1) rdy_ok = 1'b0;
    send(8'd10, 8'd10, 16'd96);
    step(); if (rdy !== 1'b1) rdy_ok = 1'b0;
    step(); if (rdy !== 1'b1) rdy_ok = 1'b0;
    send(8'd2, 8'd7, 16'd16);
    step(); if (rdy !== 1'b1) rdy_ok = 1'b0;
    step(); if (rdy !== 1'b1) rdy_ok = 1'b0;
    send(8'd255, 8'd255, 16'd65000);
    chk("bubble_ready_held", 64'(rdy_ok), 64'(1));
    s = 1'b1;
    step();
    s = 1'b0;
    wait_done(1, 3, "bubble_done_latency");
    chk_results("bubble", 18'd31, 19'd27, 16'd25, 3'd3);

    // Results held in DONE after the pulse
    step();
    step();
    chk("hold_done", 64'(dn), 64'(0));
    chk("hold_busy", 64'(bsy), 64'(0));
    chk_results("hold", 18'd31, 19'd27, 16'd25, 3'd3);

    // Maximum positive error
    pulse_start();
    for (int k = 0; k < 4; k++) send(8'd255, 8'd255, 16'd0);
    wait_done(0, 3, "pos_done_latency");
    chk_results("pos", 18'd260100, 19'd260100, 16'd65025, 3'd4);

    // Maximum negative error
    pulse_start();
    for (int k = 0; k < 4; k++) send(8'd0, 8'd0, 16'd65535);
    wait_done(0, 3, "neg_done_latency");
    chk_results("neg", 18'd262140, -19'sd262140, 16'd65535, 3'd4);

    // Exhaustive exact sweep on the full-size window
    s16 = 1'b1;
    step();
    s16 = 1'b0;
    rdy_ok = 1'b1;
    v16 = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      x16 = 8'(i >> 8);
      y16 = 8'(i);
      z16 = 16'(x16) * 16'(y16);
      if (rdy16 !== 1'b1) rdy_ok = 1'b0;
      step();
    end
    v16 = 1'b0;
    chk("sweep_ready", 64'(rdy_ok), 64'(1));
    chk("sweep_drain", 64'(rdy16), 64'(0));
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      step();
      n++;
      if (dn16 === 1'b1) seen = 1'b1;
    end
    chk("sweep_done_latency", 64'(n), 64'(3));
    chk("sweep_abs", 64'(abs16), 64'(0));
    chk("sweep_sgn", 64'(sgn16), 64'(0));
    chk("sweep_max", 64'(max16), 64'(0));
    chk("sweep_nz", 64'(nz16), 64'(0));
    chk("sweep_busy", 64'(bsy16), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
